// File: rtl/axil_wb_pkg.sv
// Shared types for the AXI4-lite read to Wishbone bridge.
//   axi_resp_t : 2-bit AXI response code (OKAY / SLVERR / DECERR)
//   rd_state_t : bridge FSM state (IDLE / BUSY / FLUSH)
package axil_wb_pkg;

  typedef logic [1:0] axi_resp_t;

  localparam axi_resp_t RESP_OKAY   = 2'b00;
  localparam axi_resp_t RESP_SLVERR = 2'b10;
  localparam axi_resp_t RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    FLUSH = 2'd2
  } rd_state_t;

endpackage

// File: rtl/axil_rsp_fifo.sv
// First-word-fall-through response FIFO with asynchronous active-high reset.
//   i_clk, i_reset     : clock, async reset (empties the FIFO)
//   i_push, i_data     : write port; dropped when full unless a pop happens in the same cycle
//   i_pop              : consume the head word; ignored when empty
//   o_data             : head word, zero while empty
//   o_empty, o_full    : occupancy flags
module axil_rsp_fifo #(
  parameter int unsigned WIDTH   = 34,
  parameter int unsigned LGDEPTH = 3
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_empty,
  output logic             o_full
);

  localparam int unsigned DEPTH = 1 << LGDEPTH;
  localparam int unsigned PW    = LGDEPTH + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push_c;
  logic             do_pop_c;

  // Extra pointer bit distinguishes full from empty.
  assign o_empty   = (wr_ptr == rd_ptr);
  assign o_full    = (wr_ptr[LGDEPTH-1:0] == rd_ptr[LGDEPTH-1:0]) &&
                     (wr_ptr[LGDEPTH] != rd_ptr[LGDEPTH]);
  assign do_pop_c  = i_pop && !o_empty;
  assign do_push_c = i_push && (!o_full || do_pop_c);

  // Head is gated so the read data reads zero whenever nothing is queued.
  assign o_data = o_empty ? '0 : mem[rd_ptr[LGDEPTH-1:0]];

  // Storage array, no reset needed: only read through the empty gate.
  always_ff @(posedge i_clk) begin
    if (do_push_c) begin
      mem[wr_ptr[LGDEPTH-1:0]] <= i_data;
    end
  end

  // Pointer update.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push_c) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop_c)  rd_ptr <= rd_ptr + PW'(1);
    end
  end

endmodule

// File: rtl/axil_rd2wb_pipe.sv
// AXI4-lite read channel to pipelined Wishbone master bridge.
// Up to 2**LGFIFO reads may be in flight; responses are buffered in a FWFT FIFO
// so R-channel backpressure never loses data. A bus error aborts the cycle and
// every still-outstanding read is answered with SLVERR, preserving AXI order.
// Optional macro AXILRD2WB_TIMEOUT_EN adds an ack timeout (TMO_CYCLES) that
// aborts like an error but answers the affected reads with DECERR.
// Ports:
//   i_clk, i_reset                  : clock, async active-high reset
//   i_axi_ar{valid,addr,prot}, o_axi_arready        : AR channel (word address)
//   o_axi_r{valid,data,resp}, i_axi_rready          : R channel
//   o_wb_{cyc,stb,addr,sel}, i_wb_{stall,ack,data,err} : Wishbone master
module axil_rd2wb_pipe
  import axil_wb_pkg::*;
#(
  parameter  int unsigned C_AXI_DATA_WIDTH = 32,
  parameter  int unsigned C_AXI_ADDR_WIDTH = 28,
  parameter  int unsigned LGFIFO           = 3,
  parameter  int unsigned TMO_CYCLES       = 255,
  localparam int unsigned DW               = C_AXI_DATA_WIDTH,
  localparam int unsigned AW               = C_AXI_ADDR_WIDTH - $clog2(C_AXI_DATA_WIDTH / 8)
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_axi_arvalid,
  output logic            o_axi_arready,
  input  logic [AW-1:0]   i_axi_araddr,
  input  logic [2:0]      i_axi_arprot,
  output logic            o_axi_rvalid,
  input  logic            i_axi_rready,
  output logic [DW-1:0]   o_axi_rdata,
  output logic [1:0]      o_axi_rresp,
  output logic            o_wb_cyc,
  output logic            o_wb_stb,
  output logic [AW-1:0]   o_wb_addr,
  output logic [DW/8-1:0] o_wb_sel,
  input  logic            i_wb_stall,
  input  logic            i_wb_ack,
  input  logic [DW-1:0]   i_wb_data,
  input  logic            i_wb_err
);

  localparam int unsigned CW   = LGFIFO + 1;
  localparam int unsigned FLEN = 1 << LGFIFO;
  localparam int unsigned TW   = $clog2(TMO_CYCLES + 1);

  rd_state_t     state, state_nxt;
  logic [CW-1:0] inflight, inflight_nxt;
  logic [CW-1:0] wbout, wbout_nxt;
  logic [CW-1:0] flushcnt, flushcnt_nxt;
  axi_resp_t     flush_resp, flush_resp_nxt;
  logic          stb_nxt;
  logic [AW-1:0] addr_nxt;

  logic          ar_hs_c, r_hs_c, wb_acc_c, ack_c, err_c, tmo_c, abort_c;
  logic          push_c;
  logic [DW+1:0] push_data_c;
  logic [DW+1:0] fifo_head;
  logic          fifo_empty, fifo_full;
  logic          unused_c;

  assign unused_c = ^{i_axi_arprot, fifo_full, TW'(TMO_CYCLES)};
  assign o_wb_sel = '1;

  // Bus events; ack/err outside BUSY are ignored and err wins over ack.
  assign ack_c    = (state == BUSY) && i_wb_ack && !i_wb_err;
  assign err_c    = (state == BUSY) && i_wb_err;
  assign abort_c  = err_c || tmo_c;
  assign wb_acc_c = o_wb_stb && !i_wb_stall;

  // No new request during an abort cycle so the flush count stays exact.
  assign o_axi_arready = !i_reset && (state != FLUSH) && (inflight < CW'(FLEN)) &&
                         (!o_wb_stb || !i_wb_stall) && !abort_c;
  assign ar_hs_c = i_axi_arvalid && o_axi_arready;
  assign r_hs_c  = o_axi_rvalid && i_axi_rready;

  assign inflight_nxt = inflight + CW'(ar_hs_c) - CW'(r_hs_c);

`ifdef AXILRD2WB_TIMEOUT_EN
  logic [TW-1:0] tmo_cnt;

  // Fires when acks stop arriving; a simultaneous ack or err takes priority.
  assign tmo_c = (state == BUSY) && (wbout != '0) && (tmo_cnt == TW'(TMO_CYCLES)) &&
                 !i_wb_ack && !i_wb_err;

  // Ack timeout counter: runs only while beats are outstanding.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      tmo_cnt <= '0;
    end else if ((state != BUSY) || (wbout == '0) || i_wb_ack || i_wb_err) begin
      tmo_cnt <= '0;
    end else if (tmo_cnt != TW'(TMO_CYCLES)) begin
      tmo_cnt <= tmo_cnt + TW'(1);
    end
  end
`else
  assign tmo_c = 1'b0;
`endif

  // Next-state, strobe and response-push logic.
  always_comb begin
    state_nxt      = state;
    wbout_nxt      = wbout;
    flushcnt_nxt   = flushcnt;
    flush_resp_nxt = flush_resp;
    stb_nxt        = o_wb_stb;
    addr_nxt       = o_wb_addr;
    push_c         = 1'b0;
    push_data_c    = '0;

    // At most one strobe is pending: a new AR is only taken as the old one leaves.
    if (ar_hs_c) begin
      stb_nxt  = 1'b1;
      addr_nxt = i_axi_araddr;
    end else if (wb_acc_c) begin
      stb_nxt = 1'b0;
    end

    case (state)
      IDLE: begin
        if (ar_hs_c) state_nxt = BUSY;
      end
      BUSY: begin
        if (abort_c) begin
          // Answer the failing beat now; the rest (acked-pending plus any
          // strobe still on the bus) are answered one per cycle in FLUSH.
          push_c         = 1'b1;
          flush_resp_nxt = tmo_c ? RESP_DECERR : RESP_SLVERR;
          push_data_c    = {flush_resp_nxt, DW'(0)};
          flushcnt_nxt   = wbout - CW'(1) + CW'(o_wb_stb);
          wbout_nxt      = '0;
          stb_nxt        = 1'b0;
          state_nxt      = (flushcnt_nxt == '0) ? IDLE : FLUSH;
        end else begin
          wbout_nxt = wbout + CW'(wb_acc_c) - CW'(ack_c);
          if (ack_c) begin
            push_c      = 1'b1;
            push_data_c = {RESP_OKAY, i_wb_data};
          end
          if ((wbout_nxt == '0) && !stb_nxt) state_nxt = IDLE;
        end
      end
      FLUSH: begin
        push_c       = 1'b1;
        push_data_c  = {flush_resp, DW'(0)};
        flushcnt_nxt = flushcnt - CW'(1);
        if (flushcnt_nxt == '0) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State and counter registers.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state      <= IDLE;
      inflight   <= '0;
      wbout      <= '0;
      flushcnt   <= '0;
      flush_resp <= RESP_OKAY;
      o_wb_cyc   <= 1'b0;
      o_wb_stb   <= 1'b0;
      o_wb_addr  <= '0;
    end else begin
      state      <= state_nxt;
      inflight   <= inflight_nxt;
      wbout      <= wbout_nxt;
      flushcnt   <= flushcnt_nxt;
      flush_resp <= flush_resp_nxt;
      o_wb_cyc   <= (state_nxt == BUSY);
      o_wb_stb   <= stb_nxt;
      o_wb_addr  <= addr_nxt;
    end
  end

  axil_rsp_fifo #(
    .WIDTH  (DW + 2),
    .LGDEPTH(LGFIFO)
  ) u_rsp_fifo (
    .i_clk  (i_clk),
    .i_reset(i_reset),
    .i_push (push_c),
    .i_data (push_data_c),
    .i_pop  (r_hs_c),
    .o_data (fifo_head),
    .o_empty(fifo_empty),
    .o_full (fifo_full)
  );

  assign o_axi_rvalid = !fifo_empty;
  assign o_axi_rdata  = fifo_head[DW-1:0];
  assign o_axi_rresp  = fifo_head[DW+1:DW];

endmodule

// File: tb/tb_axil_rd2wb_pipe.sv
// Self-checking bench for axil_rd2wb_pipe: single-read vector table plus
// hand-written pipelined, error, stall, reset and (optional) timeout sequences.
module tb_axil_rd2wb_pipe;
  import axil_wb_pkg::*;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 26;

  typedef struct {
    logic [AW-1:0] addr;
    int            lat;
    logic          ack;
    logic          err;
    logic [DW-1:0] data;
    logic [1:0]    exp_resp;
    logic [DW-1:0] exp_data;
  } rd_vec_t;

  typedef logic [DW-1:0] dlist_t [8];
  typedef logic [1:0]    rlist_t [8];

  logic          i_clk = 1'b0;
  logic          i_reset;
  logic          i_axi_arvalid;
  logic          o_axi_arready;
  logic [AW-1:0] i_axi_araddr;
  logic [2:0]    i_axi_arprot;
  logic          o_axi_rvalid;
  logic          i_axi_rready;
  logic [DW-1:0] o_axi_rdata;
  logic [1:0]    o_axi_rresp;
  logic          o_wb_cyc;
  logic          o_wb_stb;
  logic [AW-1:0] o_wb_addr;
  logic [3:0]    o_wb_sel;
  logic          i_wb_stall;
  logic          i_wb_ack;
  logic [DW-1:0] i_wb_data;
  logic          i_wb_err;

  int checks = 0;
  int errors = 0;

  always #5 i_clk = ~i_clk;

  axil_rd2wb_pipe #(
    .C_AXI_DATA_WIDTH(32),
    .C_AXI_ADDR_WIDTH(28),
    .LGFIFO          (3),
    .TMO_CYCLES      (16)
  ) dut (
    .i_clk        (i_clk),
    .i_reset      (i_reset),
    .i_axi_arvalid(i_axi_arvalid),
    .o_axi_arready(o_axi_arready),
    .i_axi_araddr (i_axi_araddr),
    .i_axi_arprot (i_axi_arprot),
    .o_axi_rvalid (o_axi_rvalid),
    .i_axi_rready (i_axi_rready),
    .o_axi_rdata  (o_axi_rdata),
    .o_axi_rresp  (o_axi_rresp),
    .o_wb_cyc     (o_wb_cyc),
    .o_wb_stb     (o_wb_stb),
    .o_wb_addr    (o_wb_addr),
    .o_wb_sel     (o_wb_sel),
    .i_wb_stall   (i_wb_stall),
    .i_wb_ack     (i_wb_ack),
    .i_wb_data    (i_wb_data),
    .i_wb_err     (i_wb_err)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #2;
  endtask

  // Present one AR and hold it until accepted (bounded).
  task automatic ar_issue(input logic [AW-1:0] a);
    bit done = 1'b0;
    i_axi_arvalid = 1'b1;
    i_axi_araddr  = a;
    for (int n = 0; n < 50 && !done; n++) begin
      #1;
      if (o_axi_arready) done = 1'b1;
      tick();
    end
    i_axi_arvalid = 1'b0;
    chk("ar_accept", 64'(done), 64'(1));
  endtask

  task automatic wb_ack_beat(input logic [DW-1:0] d);
    i_wb_ack  = 1'b1;
    i_wb_data = d;
    tick();
    i_wb_ack  = 1'b0;
  endtask

  // Issue cnt ARs with arvalid held high; stall is 0 so each should take one cycle.
  task automatic issue_burst(input logic [AW-1:0] base, input int cnt, input string tag);
    int k = 0;
    int n = 0;
    i_axi_arvalid = 1'b1;
    i_axi_araddr  = base;
    while (k < cnt && n < 40) begin
      #1;
      if (o_axi_arready) begin
        tick();
        chk($sformatf("%s_stb%0d", tag, k), 64'(o_wb_stb), 64'(1));
        chk($sformatf("%s_addr%0d", tag, k), 64'(o_wb_addr), 64'(base + AW'(k)));
        k++;
        i_axi_araddr = base + AW'(k);
      end else begin
        tick();
      end
      n++;
    end
    i_axi_arvalid = 1'b0;
    chk($sformatf("%s_cycles", tag), 64'(n), 64'(cnt));
    tick();
    chk($sformatf("%s_stb_done", tag), 64'(o_wb_stb), 64'(0));
  endtask

  task automatic drain(input int n, input dlist_t d, input rlist_t r, input string tag);
    i_axi_rready = 1'b1;
    for (int i = 0; i < n; i++) begin
      #1;
      chk($sformatf("%s_rvalid%0d", tag, i), 64'(o_axi_rvalid), 64'(1));
      chk($sformatf("%s_rdata%0d", tag, i), 64'(o_axi_rdata), 64'(d[i]));
      chk($sformatf("%s_rresp%0d", tag, i), 64'(o_axi_rresp), 64'(r[i]));
      tick();
    end
    #1;
    chk($sformatf("%s_empty", tag), 64'(o_axi_rvalid), 64'(0));
    i_axi_rready = 1'b0;
  endtask

  task automatic do_read(input rd_vec_t v, input int idx);
    i_axi_rready = 1'b1;
    ar_issue(v.addr);
    chk($sformatf("vec%0d_stb", idx), 64'(o_wb_stb), 64'(1));
    chk($sformatf("vec%0d_addr", idx), 64'(o_wb_addr), 64'(v.addr));
    chk($sformatf("vec%0d_cyc", idx), 64'(o_wb_cyc), 64'(1));
    repeat (v.lat) tick();
    i_wb_ack  = v.ack;
    i_wb_err  = v.err;
    i_wb_data = v.data;
    tick();
    i_wb_ack = 1'b0;
    i_wb_err = 1'b0;
    #1;
    chk($sformatf("vec%0d_cyc_drop", idx), 64'(o_wb_cyc), 64'(0));
    chk($sformatf("vec%0d_rvalid", idx), 64'(o_axi_rvalid), 64'(1));
    chk($sformatf("vec%0d_rdata", idx), 64'(o_axi_rdata), 64'(v.exp_data));
    chk($sformatf("vec%0d_rresp", idx), 64'(o_axi_rresp), 64'(v.exp_resp));
    tick();
    #1;
    chk($sformatf("vec%0d_popped", idx), 64'(o_axi_rvalid), 64'(0));
    chk($sformatf("vec%0d_arready", idx), 64'(o_axi_arready), 64'(1));
    i_axi_rready = 1'b0;
  endtask

  initial begin
    rd_vec_t vecs [6];
    dlist_t  ed;
    rlist_t  er;

    vecs[0] = '{addr: 26'h10,      lat: 2, ack: 1'b1, err: 1'b0, data: 32'hCAFEF00D,
                exp_resp: RESP_OKAY,   exp_data: 32'hCAFEF00D};
    vecs[1] = '{addr: 26'h3FFFFFF, lat: 1, ack: 1'b1, err: 1'b0, data: 32'hFFFFFFFF,
                exp_resp: RESP_OKAY,   exp_data: 32'hFFFFFFFF};
    vecs[2] = '{addr: 26'h0,       lat: 4, ack: 1'b1, err: 1'b0, data: 32'h00000000,
                exp_resp: RESP_OKAY,   exp_data: 32'h00000000};
    vecs[3] = '{addr: 26'h155,     lat: 1, ack: 1'b0, err: 1'b1, data: 32'h12345678,
                exp_resp: RESP_SLVERR, exp_data: 32'h00000000};
    vecs[4] = '{addr: 26'h2AA,     lat: 3, ack: 1'b1, err: 1'b1, data: 32'hA5A5A5A5,
                exp_resp: RESP_SLVERR, exp_data: 32'h00000000};
    vecs[5] = '{addr: 26'h1234,    lat: 1, ack: 1'b1, err: 1'b0, data: 32'h5A5A0F0F,
                exp_resp: RESP_OKAY,   exp_data: 32'h5A5A0F0F};

    i_reset       = 1'b1;
    i_axi_arvalid = 1'b0;
    i_axi_araddr  = '0;
    i_axi_arprot  = 3'b0;
    i_axi_rready  = 1'b0;
    i_wb_stall    = 1'b0;
    i_wb_ack      = 1'b0;
    i_wb_data     = '0;
    i_wb_err      = 1'b0;

    // Reset state
    #3;
    chk("rst_cyc", 64'(o_wb_cyc), 64'(0));
    chk("rst_stb", 64'(o_wb_stb), 64'(0));
    chk("rst_rvalid", 64'(o_axi_rvalid), 64'(0));
    chk("rst_arready", 64'(o_axi_arready), 64'(0));
    chk("rst_rresp", 64'(o_axi_rresp), 64'(RESP_OKAY));
    chk("rst_rdata", 64'(o_axi_rdata), 64'(0));
    chk("rst_sel", 64'(o_wb_sel), 64'(4'hF));
    tick();
    tick();
    i_reset = 1'b0;
    #1;
    chk("post_rst_arready", 64'(o_axi_arready), 64'(1));

    // Single-read vector table
    for (int i = 0; i < 6; i++) do_read(vecs[i], i);

    // Eight back-to-back reads with R held off, then drained in order
    issue_burst(26'h100, 8, "b2b");
    #1;
    chk("b2b_full_arready", 64'(o_axi_arready), 64'(0));
    for (int i = 0; i < 8; i++) begin
      ed[i] = 32'hC0DE0000 + DW'(i);
      er[i] = RESP_OKAY;
      wb_ack_beat(ed[i]);
    end
    #1;
    chk("b2b_cyc_drop", 64'(o_wb_cyc), 64'(0));
    chk("b2b_head", 64'(o_axi_rdata), 64'(32'hC0DE0000));
    chk("b2b_arready_still0", 64'(o_axi_arready), 64'(0));
    tick();
    chk("b2b_head_hold", 64'(o_axi_rdata), 64'(32'hC0DE0000));
    chk("b2b_rvalid_hold", 64'(o_axi_rvalid), 64'(1));
    drain(8, ed, er, "b2b");
    chk("b2b_arready_back", 64'(o_axi_arready), 64'(1));

    // Error on the second of four acks
    issue_burst(26'h200, 4, "err");
    wb_ack_beat(32'h11111111);
    i_wb_err = 1'b1;
    tick();
    i_wb_err = 1'b0;
    #1;
    chk("err_cyc_drop", 64'(o_wb_cyc), 64'(0));
    chk("err_stb_drop", 64'(o_wb_stb), 64'(0));
    chk("err_arready_f1", 64'(o_axi_arready), 64'(0));
    tick();
    #1;
    chk("err_arready_f2", 64'(o_axi_arready), 64'(0));
    tick();
    #1;
    chk("err_arready_idle", 64'(o_axi_arready), 64'(1));
    ed[0] = 32'h11111111;
    er[0] = RESP_OKAY;
    for (int i = 1; i < 4; i++) begin
      ed[i] = '0;
      er[i] = RESP_SLVERR;
    end
    drain(4, ed, er, "err");

    // Stall held for five cycles with a second AR waiting
    i_wb_stall    = 1'b1;
    i_axi_arvalid = 1'b1;
    i_axi_araddr  = 26'h40;
    #1;
    chk("stall_first_arready", 64'(o_axi_arready), 64'(1));
    tick();
    i_axi_araddr = 26'h41;
    for (int n = 0; n < 5; n++) begin
      #1;
      chk($sformatf("stall_arready%0d", n), 64'(o_axi_arready), 64'(0));
      chk($sformatf("stall_stb%0d", n), 64'(o_wb_stb), 64'(1));
      chk($sformatf("stall_addr%0d", n), 64'(o_wb_addr), 64'(26'h40));
      tick();
    end
    i_wb_stall = 1'b0;
    #1;
    chk("stall_release_arready", 64'(o_axi_arready), 64'(1));
    tick();
    i_axi_arvalid = 1'b0;
    chk("stall_next_stb", 64'(o_wb_stb), 64'(1));
    chk("stall_next_addr", 64'(o_wb_addr), 64'(26'h41));
    tick();
    chk("stall_stb_done", 64'(o_wb_stb), 64'(0));
    wb_ack_beat(32'hAAAA0040);
    #1;
    chk("stall_cyc_mid", 64'(o_wb_cyc), 64'(1));
    wb_ack_beat(32'hAAAA0041);
    #1;
    chk("stall_cyc_drop", 64'(o_wb_cyc), 64'(0));
    ed[0] = 32'hAAAA0040;
    ed[1] = 32'hAAAA0041;
    er[0] = RESP_OKAY;
    er[1] = RESP_OKAY;
    drain(2, ed, er, "stall");

    // Reset mid-BUSY with 3 outstanding and 2 queued
    issue_burst(26'h300, 5, "rst");
    wb_ack_beat(32'h33330000);
    wb_ack_beat(32'h33330001);
    #1;
    chk("rst_pre_rvalid", 64'(o_axi_rvalid), 64'(1));
    chk("rst_pre_cyc", 64'(o_wb_cyc), 64'(1));
    i_reset = 1'b1;
    #1;
    chk("rst_mid_cyc", 64'(o_wb_cyc), 64'(0));
    chk("rst_mid_rvalid", 64'(o_axi_rvalid), 64'(0));
    chk("rst_mid_stb", 64'(o_wb_stb), 64'(0));
    chk("rst_mid_arready", 64'(o_axi_arready), 64'(0));
    tick();
    i_reset = 1'b0;
    do_read(vecs[0], 10);

`ifdef AXILRD2WB_TIMEOUT_EN
    // Two reads that are never acked
    begin
      int n = 0;
      ar_issue(26'h30);
      ar_issue(26'h31);
      while (o_wb_cyc && n < 100) begin
        tick();
        n++;
      end
      chk("tmo_cyc_drop", 64'(o_wb_cyc), 64'(0));
      chk("tmo_min_wait", 64'(n >= 16), 64'(1));
      ed[0] = '0;
      ed[1] = '0;
      er[0] = RESP_DECERR;
      er[1] = RESP_DECERR;
      drain(2, ed, er, "tmo");
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
